// File: rtl/life_gen_sequencer.sv
// Generation sequencer for the Life PE array: launches snapshot/update handshakes
// inside vertical blanking and arbitrates clear, single-step and seed-load access.
module life_gen_sequencer #(
  parameter int FPG_BITS    = 8,
  parameter int GEN_BITS    = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vblank_start,
  input  logic                vblank,
  input  logic                run,
  input  logic                step,
  input  logic                clear,
  input  logic                seed_req,
  input  logic [FPG_BITS-1:0] frames_per_gen,
  input  logic                pe_done,
  output logic                pe_snapshot,
  output logic                pe_update,
  output logic                pe_clear,
  output logic                seed_grant,
  output logic                busy,
  output logic [GEN_BITS-1:0] gen_count,
  output logic                timeout_err
);

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNAP     = 3'd1,
    UPDATE   = 3'd2,
    WAIT_ACK = 3'd3,
    CLEAR    = 3'd4,
    SEED     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [FPG_BITS-1:0] fcnt_q, fcnt_d;
  logic                step_pending_q, step_pending_d;
  logic                clear_pending_q, clear_pending_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [GEN_BITS-1:0] gen_count_q, gen_count_d;
  logic                timeout_err_q, timeout_err_d;
  logic                pe_snapshot_q, pe_snapshot_d;
  logic                pe_update_q, pe_update_d;
  logic                pe_clear_q, pe_clear_d;
  logic                seed_grant_q, seed_grant_d;
  logic                busy_q, busy_d;

  logic [FPG_BITS:0]   fpg_eff;
  logic [FPG_BITS:0]   fcnt_inc;
  logic                go;

  // Blanking level is informational only: an overrunning update is caught by the ack timeout.
  logic                vblank_unused;
  assign vblank_unused = vblank;

  function automatic logic [FPG_BITS:0] fpg_at_least_one(input logic [FPG_BITS-1:0] fpg);
    if (fpg == '0) return (FPG_BITS+1)'(1);
    return {1'b0, fpg};
  endfunction

  always_comb begin
    fpg_eff  = fpg_at_least_one(frames_per_gen);
    fcnt_inc = {1'b0, fcnt_q} + (FPG_BITS+1)'(1);
  end

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    step_pending_d  = step_pending_q;
    clear_pending_d = clear_pending_q;
    tmo_d           = tmo_q;
    gen_count_d     = gen_count_q;
    timeout_err_d   = timeout_err_q;
    go              = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear || clear_pending_q) begin
          state_d = CLEAR;
        end else if (seed_req) begin
          state_d = SEED;
        end else if (vblank_start) begin
          if (run) begin
            if (fcnt_inc >= fpg_eff) begin
              go     = 1'b1;
              fcnt_d = '0;
            end else begin
              fcnt_d = fcnt_inc[FPG_BITS-1:0];
            end
          end
          if (go || step_pending_q) begin
            state_d = SNAP;
            // A frame-rate launch leaves a pending step for a later blanking interval.
            if (!go) step_pending_d = 1'b0;
          end
        end
      end
      SNAP: begin
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d = WAIT_ACK;
        tmo_d   = TMO_LOAD;
      end
      WAIT_ACK: begin
        if (pe_done) begin
          gen_count_d = gen_count_q + GEN_BITS'(1);
          state_d     = IDLE;
        end else if (tmo_q == TMO_W'(1)) begin
          timeout_err_d = 1'b1;
          tmo_d         = '0;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      SEED: begin
        if (!seed_req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear && (state_q == SNAP || state_q == UPDATE || state_q == WAIT_ACK))
      clear_pending_d = 1'b1;
    if (step && state_q != SEED)
      step_pending_d = 1'b1;

    // Entering CLEAR wipes all bookkeeping in the same edge that raises pe_clear.
    if (state_d == CLEAR) begin
      gen_count_d     = '0;
      fcnt_d          = '0;
      step_pending_d  = 1'b0;
      clear_pending_d = 1'b0;
      timeout_err_d   = 1'b0;
    end

    pe_snapshot_d = (state_d == SNAP);
    pe_update_d   = (state_d == UPDATE);
    pe_clear_d    = (state_d == CLEAR);
    busy_d        = (state_d != IDLE);
    seed_grant_d  = (state_q == SEED) && (state_d == SEED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      fcnt_q          <= '0;
      step_pending_q  <= 1'b0;
      clear_pending_q <= 1'b0;
      tmo_q           <= '0;
      gen_count_q     <= '0;
      timeout_err_q   <= 1'b0;
      pe_snapshot_q   <= 1'b0;
      pe_update_q     <= 1'b0;
      pe_clear_q      <= 1'b0;
      seed_grant_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      step_pending_q  <= step_pending_d;
      clear_pending_q <= clear_pending_d;
      tmo_q           <= tmo_d;
      gen_count_q     <= gen_count_d;
      timeout_err_q   <= timeout_err_d;
      pe_snapshot_q   <= pe_snapshot_d;
      pe_update_q     <= pe_update_d;
      pe_clear_q      <= pe_clear_d;
      seed_grant_q    <= seed_grant_d;
      busy_q          <= busy_d;
    end
  end

  assign pe_snapshot = pe_snapshot_q;
  assign pe_update   = pe_update_q;
  assign pe_clear    = pe_clear_q;
  assign seed_grant  = seed_grant_q;
  assign busy        = busy_q;
  assign gen_count   = gen_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: random frames against a frame-level model plus
// directed handshake, clear, seed, timeout and reset scenarios.
module tb_life_gen_sequencer;
  localparam int FPG_BITS    = 8;
  localparam int GEN_BITS    = 16;
  localparam int ACK_TIMEOUT = 64;
  localparam int FRAME_LEN   = 30;

  logic                clk = 1'b0;
  logic                reset, vblank_start, vblank, run, step, clear, seed_req, pe_done;
  logic [FPG_BITS-1:0] frames_per_gen;
  logic                pe_snapshot, pe_update, pe_clear, seed_grant, busy, timeout_err;
  logic [GEN_BITS-1:0] gen_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_delay = 5;
  int done_at   = -1;
  int n_snap = 0, n_upd = 0, n_clr = 0;
  int last_snap = -10;

  life_gen_sequencer #(
    .FPG_BITS(FPG_BITS), .GEN_BITS(GEN_BITS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .vblank_start(vblank_start), .vblank(vblank),
    .run(run), .step(step), .clear(clear), .seed_req(seed_req),
    .frames_per_gen(frames_per_gen), .pe_done(pe_done),
    .pe_snapshot(pe_snapshot), .pe_update(pe_update), .pe_clear(pe_clear),
    .seed_grant(seed_grant), .busy(busy), .gen_count(gen_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Array model and pulse monitor, sampled mid-cycle.
  initial begin
    pe_done = 1'b0;
    forever begin
      @(negedge clk);
      pe_done = (ack_delay >= 0) && (cyc == done_at);
      if (pe_update) begin
        n_upd++;
        chk("upd_after_snap", 64'(last_snap), 64'(cyc - 1));
        if (ack_delay >= 0) done_at = cyc + ack_delay;
      end
      if (pe_snapshot) begin
        n_snap++;
        last_snap = cyc;
      end
      if (pe_clear) n_clr++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vblank_start = 1'b0; vblank = 1'b0; step = 1'b0;
    clear = 1'b0; seed_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic frame(input bit do_step, output bit snapped);
    vblank_start = 1'b1; vblank = 1'b1;
    tick();
    vblank_start = 1'b0;
    snapped = pe_snapshot;
    for (int k = 1; k < FRAME_LEN; k++) begin
      if (k == 12) vblank = 1'b0;
      step = do_step && (k == 15);
      tick();
    end
    step = 1'b0;
  endtask

  // Step-launched generation; returns in the pe_update cycle.
  task automatic launch_by_step(input string tag);
    step = 1'b1; tick(); step = 1'b0; tick();
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
    chk({tag, "_snap"}, pe_snapshot, 1);
    tick();
    chk({tag, "_upd"}, pe_update, 1);
  endtask

  initial begin
    int  m_fcnt, m_gen, fpg_eff, base_s, base_u, k;
    bit  m_step, go, launch, s, s2, do_step;

    reset = 1'b1; vblank_start = 1'b0; vblank = 1'b0; run = 1'b0; step = 1'b0;
    clear = 1'b0; seed_req = 1'b0; frames_per_gen = 8'd1;
    tick(); tick();
    chk("rst_snap", pe_snapshot, 0);
    chk("rst_upd", pe_update, 0);
    chk("rst_clr", pe_clear, 0);
    chk("rst_grant", seed_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_terr", timeout_err, 0);
    reset = 1'b0;

    // Random frames against a frame-level model of the divider and step logic.
    m_fcnt = 0; m_gen = 0; m_step = 0;
    for (int i = 0; i < 40; i++) begin
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) frames_per_gen = FPG_BITS'($urandom_range(0, 4));
      ack_delay = $urandom_range(1, 8);
      do_step = ($urandom_range(0, 2) == 0);
      go = 0;
      if (run) begin
        m_fcnt++;
        fpg_eff = (frames_per_gen == 0) ? 1 : int'(frames_per_gen);
        if (m_fcnt >= fpg_eff) begin go = 1; m_fcnt = 0; end
      end
      launch = go || m_step;
      if (launch && !go) m_step = 0;
      if (launch) m_gen = (m_gen + 1) % (1 << GEN_BITS);
      frame(do_step, s);
      if (do_step) m_step = 1;
      chk("rnd_snap", s, launch);
      chk("rnd_gen", gen_count, 64'(m_gen));
      chk("rnd_idle", busy, 0);
    end

    // Free run, divide by 3.
    do_reset();
    run = 1'b1; frames_per_gen = 8'd3; ack_delay = 5;
    base_s = n_snap; base_u = n_upd;
    for (int i = 0; i < 9; i++) begin
      frame(0, s);
      chk("free_snap", s, (i % 3 == 2));
    end
    chk("free_nsnap", 64'(n_snap - base_s), 3);
    chk("free_nupd", 64'(n_upd - base_u), 3);
    chk("free_gen", gen_count, 3);

    // Step while paused, including a dropped second step.
    do_reset();
    run = 1'b0; frames_per_gen = 8'd1; ack_delay = 3;
    base_s = n_snap;
    repeat (5) tick();
    step = 1'b1; tick(); step = 1'b0;
    repeat (10) tick();
    chk("step_nopulse", 64'(n_snap - base_s), 0);
    frame(0, s);
    chk("step_snap", s, 1);
    chk("step_gen1", gen_count, 1);
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    frame(0, s);
    frame(0, s2);
    chk("step2_snap", s, 1);
    chk("step2_extra", s2, 0);
    chk("step2_gen", gen_count, 2);

    // Clear during WAIT_ACK.
    do_reset();
    run = 1'b0; ack_delay = 5;
    launch_by_step("cw");
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    k = 0;
    while (k < 20 && gen_count != 1) begin tick(); k++; end
    chk("cw_gen1", gen_count, 1);
    chk("cw_noclr_yet", pe_clear, 0);
    chk("cw_idle", busy, 0);
    tick();
    chk("cw_pe_clear", pe_clear, 1);
    chk("cw_gen0", gen_count, 0);
    chk("cw_busy_clear", busy, 1);

    // Clear with seed request, then seed exclusivity.
    do_reset();
    run = 1'b1; frames_per_gen = 8'd1; ack_delay = 4;
    clear = 1'b1; seed_req = 1'b1; tick(); clear = 1'b0;
    chk("cs_clear_first", pe_clear, 1);
    chk("cs_no_grant", seed_grant, 0);
    tick(); tick(); tick();
    chk("seed_grant_on", seed_grant, 1);
    base_s = n_snap;
    frame(0, s);
    frame(0, s2);
    chk("seed_no_snap1", s, 0);
    chk("seed_no_snap2", s2, 0);
    chk("seed_nsnap", 64'(n_snap - base_s), 0);
    chk("seed_grant_held", seed_grant, 1);
    chk("seed_busy", busy, 1);
    seed_req = 1'b0; tick();
    chk("seed_grant_off", seed_grant, 0);
    chk("seed_idle", busy, 0);
    frame(0, s);
    chk("seed_after_snap", s, 1);
    chk("seed_after_gen", gen_count, 1);

    // Ack on the final cycle of the window counts as success.
    do_reset();
    run = 1'b0; ack_delay = ACK_TIMEOUT;
    launch_by_step("late");
    repeat (ACK_TIMEOUT + 1) tick();
    chk("late_gen", gen_count, 1);
    chk("late_terr", timeout_err, 0);
    chk("late_idle", busy, 0);

    // No ack at all.
    ack_delay = -1;
    launch_by_step("to");
    repeat (ACK_TIMEOUT) tick();
    chk("to_not_yet", timeout_err, 0);
    chk("to_still_busy", busy, 1);
    tick();
    chk("to_terr", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_gen_same", gen_count, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("to_clr_pulse", pe_clear, 1);
    chk("to_clr_terr", timeout_err, 0);
    chk("to_clr_gen", gen_count, 0);

    // Reset while in SNAP.
    do_reset();
    run = 1'b0; ack_delay = 3;
    step = 1'b1; tick(); step = 1'b0;
    frame(0, s);
    chk("rs_pre_gen", gen_count, 1);
    step = 1'b1; tick(); step = 1'b0; tick();
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
    chk("rs_in_snap", pe_snapshot, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    base_u = n_upd;
    chk("rs_snap", pe_snapshot, 0);
    chk("rs_upd", pe_update, 0);
    chk("rs_clr", pe_clear, 0);
    chk("rs_grant", seed_grant, 0);
    chk("rs_busy", busy, 0);
    chk("rs_gen", gen_count, 0);
    chk("rs_terr", timeout_err, 0);
    repeat (5) tick();
    chk("rs_no_update", 64'(n_upd - base_u), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
